// File: rtl/crc32_frame_seq.sv
// Frame sequencer for an external 8-bit CRC-32 engine: TX appends the FCS, RX checks it.
// Optional good/bad frame statistics are enabled with CRC32_FRAME_STATS_EN.
module crc32_frame_seq #(
    parameter int unsigned MAX_LEN = 1518,
    parameter int unsigned MIN_LEN = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode_tx,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_data,
    output logic        m_last,
    output logic        crc_clken,
    output logic        crc_reset,
    output logic        crc_load,
    output logic        crc_compute,
    output logic [7:0]  crc_data,
    input  logic [7:0]  crc_dout,
    input  logic        crc_ok,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [15:0] frame_len,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        DATA,
        FCS,
        DONE,
        CHECK
    } state_t;

    localparam logic [16:0] MAX_L = 17'(MAX_LEN);
    localparam logic [15:0] MIN_L = 16'(MIN_LEN);

    state_t      state;
    logic        tx;
    logic        len_err;
    logic [1:0]  cnt;
    logic        hs;
    logic [16:0] len_inc;
    logic [15:0] len_sat;

    assign hs      = (state == DATA) && s_valid && m_ready;
    assign len_inc = {1'b0, frame_len} + 17'd1;
    assign len_sat = (frame_len == 16'hFFFF) ? frame_len : len_inc[15:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b0;
            len_err   <= 1'b0;
            cnt       <= 2'd0;
            frame_len <= 16'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (s_valid) begin
                        tx    <= mode_tx;
                        state <= INIT;
                    end
                end
                INIT: begin
                    frame_len <= 16'd0;
                    len_err   <= 1'b0;
                    cnt       <= 2'd0;
                    state     <= DATA;
                end
                DATA: begin
                    if (hs) begin
                        frame_len <= len_sat;
                        if (len_inc > MAX_L)
                            len_err <= 1'b1;
                        if (s_last) begin
                            if (tx) begin
                                cnt   <= 2'd0;
                                state <= FCS;
                            end else begin
                                // minimum length counts the byte just accepted
                                if (len_sat < MIN_L)
                                    len_err <= 1'b1;
                                state <= CHECK;
                            end
                        end
                    end
                end
                FCS: begin
                    if (m_ready) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3)
                            state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                CHECK:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        s_ready     = 1'b0;
        m_valid     = 1'b0;
        m_data      = 8'h00;
        m_last      = 1'b0;
        crc_reset   = 1'b0;
        crc_load    = 1'b0;
        crc_compute = 1'b0;
        crc_data    = 8'h00;
        frame_done  = 1'b0;
        frame_ok    = 1'b0;
        unique case (state)
            INIT: crc_reset = 1'b1;
            DATA: begin
                s_ready     = m_ready;
                m_valid     = s_valid;
                m_data      = s_data;
                m_last      = s_last & ~tx;
                crc_compute = hs;
                crc_data    = hs ? s_data : 8'h00;
            end
            FCS: begin
                m_valid  = 1'b1;
                m_data   = crc_dout;
                m_last   = (cnt == 2'd3);
                crc_load = m_ready;
            end
            DONE: begin
                frame_done = 1'b1;
                frame_ok   = 1'b1;
            end
            CHECK: begin
                frame_done = 1'b1;
                frame_ok   = crc_ok & ~len_err;
            end
            default: ;
        endcase
    end

    assign crc_clken = crc_reset | crc_load | crc_compute;

`ifdef CRC32_FRAME_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            good_cnt <= 16'd0;
            bad_cnt  <= 16'd0;
        end else if (frame_done) begin
            if (frame_ok)
                good_cnt <= good_cnt + 16'd1;
            else
                bad_cnt <= bad_cnt + 16'd1;
        end
    end
`else
    assign good_cnt = 16'd0;
    assign bad_cnt  = 16'd0;
`endif

endmodule

// File: tb/tb_crc32_frame_seq.sv
// Bench for crc32_frame_seq with a behavioural CRC-32 engine and frame-level model.
// The DUT uses MAX_LEN = 13 so the 13-byte check frame sits exactly on the limit.
module tb_crc32_frame_seq;

    localparam int MAXL = 13;
    localparam int MINL = 4;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mode_tx = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = 8'h00;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [7:0]  m_data;
    logic        m_last;
    logic        crc_clken;
    logic        crc_reset;
    logic        crc_load;
    logic        crc_compute;
    logic [7:0]  crc_data;
    logic [7:0]  crc_dout;
    logic        crc_ok;
    logic        frame_done;
    logic        frame_ok;
    logic [15:0] frame_len;
    logic [15:0] good_cnt;
    logic [15:0] bad_cnt;

    crc32_frame_seq #(.MAX_LEN(MAXL), .MIN_LEN(MINL)) dut (
        .clk(clk), .reset(reset), .mode_tx(mode_tx),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .crc_clken(crc_clken), .crc_reset(crc_reset), .crc_load(crc_load),
        .crc_compute(crc_compute), .crc_data(crc_data), .crc_dout(crc_dout),
        .crc_ok(crc_ok), .frame_done(frame_done), .frame_ok(frame_ok),
        .frame_len(frame_len), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic fb;
        c = c_in;
        for (int b = 7; b >= 0; b--) begin
            fb = c[31] ^ d[b];
            c = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C11DB7;
        end
        return c;
    endfunction

    function automatic logic [31:0] crc_run(input bq_t q);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (q[i]) c = crc_step(c, q[i]);
        return c;
    endfunction

    // external engine: MSB-first register, dout is the inverted top byte
    logic [31:0] e_crc = 32'hFFFFFFFF;
    assign crc_dout = ~e_crc[31:24];
    assign crc_ok   = (e_crc == 32'hC704DD7B);

    always @(posedge clk) begin
        if (crc_clken) begin
            if (crc_reset)        e_crc <= 32'hFFFFFFFF;
            else if (crc_compute) e_crc <= crc_step(e_crc, crc_data);
            else if (crc_load)    e_crc <= {e_crc[23:0], 8'h00};
        end
    end

    logic [8:0]  exp_q[$];
    logic        exp_ok = 1'b0;
    int          exp_len = 0;
    int          exp_good = 0;
    int          exp_bad = 0;
    int          done_cnt = 0;
    int          done_base = 0;
    int          load_cnt = 0;
    logic [7:0]  out_log[$];
    logic        last_ok = 1'b0;
    logic [15:0] last_len = 16'd0;
    logic        prev_stall = 1'b0;
    logic [8:0]  prev_out = 9'd0;
    logic        tog = 1'b0;

    always @(negedge clk) begin
        logic [8:0] e;
        check("clken", {31'd0, crc_clken}, {31'd0, crc_reset | crc_load | crc_compute});
        if (crc_compute)
            check("eng_data", {23'd0, s_valid, crc_data}, {23'd0, 1'b1, s_data});
        if (crc_load) load_cnt++;
        if (m_valid && prev_stall)
            check("hold", {23'd0, m_last, m_data}, {23'd0, prev_out});
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL extra_byte: got %0h expected none", {m_last, m_data});
            end else begin
                e = exp_q.pop_front();
                check("m_byte", {23'd0, m_last, m_data}, {23'd0, e});
                out_log.push_back(m_data);
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_out   = {m_last, m_data};
        if (frame_done) begin
            check("frame_ok", {31'd0, frame_ok}, {31'd0, exp_ok});
            check("frame_len", {16'd0, frame_len}, 32'(exp_len));
            last_ok  = frame_ok;
            last_len = frame_len;
            done_cnt++;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            m_ready = tog ? ~m_ready : 1'b1;
        end
    end

    task automatic start_frame(input bit tx, input bq_t p);
        int n;
        int i;
        int guard;
        logic [31:0] c;
        logic hs;
        n = p.size();
        foreach (p[k]) exp_q.push_back({(!tx && k == n - 1), p[k]});
        if (tx) begin
            c = ~crc_run(p);
            exp_q.push_back({1'b0, c[31:24]});
            exp_q.push_back({1'b0, c[23:16]});
            exp_q.push_back({1'b0, c[15:8]});
            exp_q.push_back({1'b1, c[7:0]});
            exp_ok = 1'b1;
        end else begin
            exp_ok = (n >= MINL) && (n <= MAXL) && (crc_run(p) == 32'hC704DD7B);
        end
        exp_len   = n;
        done_base = done_cnt;
        mode_tx   = tx;
        s_valid   = 1'b1;
        s_data    = p[0];
        s_last    = (n == 1);
        i = 0;
        guard = 0;
        while (i < n && guard < 500) begin
            @(negedge clk);
            hs = s_valid && s_ready;
            @(posedge clk);
            #1;
            guard++;
            mode_tx = ~tx;
            if (hs) begin
                i++;
                if (i < n) begin
                    s_data = p[i];
                    s_last = (i == n - 1);
                end else begin
                    s_valid = 1'b0;
                    s_last  = 1'b0;
                    s_data  = 8'hA5;
                end
            end
        end
        if (i < n) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got %0d bytes expected %0d", i, n);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (done_cnt == done_base && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("done_seen", {31'd0, done_cnt > done_base}, 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        if (exp_ok) exp_good++;
        else        exp_bad++;
        @(negedge clk);
        @(negedge clk);
`ifdef CRC32_FRAME_STATS_EN
        check("good_cnt", {16'd0, good_cnt}, 32'(exp_good));
        check("bad_cnt", {16'd0, bad_cnt}, 32'(exp_bad));
`else
        check("stats_off", {good_cnt, bad_cnt}, 32'd0);
`endif
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, {23'd0, m_valid, s_ready, m_last, crc_clken, crc_reset,
                              crc_load, crc_compute, frame_done, frame_ok}, 32'd0);
        check({tag, "_data"}, {16'd0, m_data, crc_data}, 32'd0);
        check({tag, "_len"}, {16'd0, frame_len}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t p1, p2, p3, p4, p5, p6, p7;
        logic [31:0] c;
        int l0;
        int d0;
        int guard;

        for (int k = 0; k < 9; k++) p1.push_back(8'h31 + 8'(k));
        check("model_crc", ~crc_run(p1), 32'hFC891918);

        repeat (2) @(posedge clk);
        #1;
        check_quiet("reset");
        check("reset_stats", {good_cnt, bad_cnt}, 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // TX "123456789"
        out_log.delete();
        start_frame(1'b1, p1);
        wait_done();
        check("tx_len13", 32'(out_log.size()), 32'd13);
        if (out_log.size() == 13)
            check("tx_fcs", {out_log[9], out_log[10], out_log[11], out_log[12]}, 32'hFC891918);
        check("tx_ok", {31'd0, last_ok}, 32'd1);

        // RX good frame, length at MAX_LEN
        p2 = p1;
        p2.push_back(8'hFC);
        p2.push_back(8'h89);
        p2.push_back(8'h19);
        p2.push_back(8'h18);
        start_frame(1'b0, p2);
        wait_done();
        check("rx_good", {15'd0, last_ok, last_len}, {15'd0, 1'b1, 16'd13});

        // RX corrupted FCS
        p3 = p2;
        p3[12] = 8'h19;
        start_frame(1'b0, p3);
        wait_done();
        check("rx_bad", {31'd0, last_ok}, 32'd0);

        // TX one byte with m_ready toggling
        p4.push_back(8'h00);
        tog = 1'b1;
        l0 = load_cnt;
        start_frame(1'b1, p4);
        wait_done();
        tog = 1'b0;
        check("load_pulses", 32'(load_cnt - l0), 32'd4);

        // RX too short
        p5.push_back(8'h01);
        p5.push_back(8'h02);
        p5.push_back(8'h03);
        start_frame(1'b0, p5);
        wait_done();
        check("rx_short", {31'd0, last_ok}, 32'd0);

        // RX minimum length: FCS of an empty payload
        for (int k = 0; k < 4; k++) p6.push_back(8'h00);
        start_frame(1'b0, p6);
        wait_done();
        check("rx_min", {31'd0, last_ok}, 32'd1);

        // RX one byte over MAX_LEN with a valid FCS
        for (int k = 0; k < 10; k++) p7.push_back(8'(k + 1));
        c = ~crc_run(p7);
        p7.push_back(c[31:24]);
        p7.push_back(c[23:16]);
        p7.push_back(c[15:8]);
        p7.push_back(c[7:0]);
        start_frame(1'b0, p7);
        wait_done();
        check("rx_long", {15'd0, last_ok, last_len}, {15'd0, 1'b0, 16'd14});

        // reset after two FCS bytes
        start_frame(1'b1, p1);
        l0 = load_cnt;
        d0 = done_cnt;
        guard = 0;
        while (load_cnt < l0 + 2 && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("fcs_two", 32'(load_cnt - l0), 32'd2);
        reset = 1'b1;
        #1;
        check_quiet("abort");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_good = 0;
        exp_bad = 0;
        check("abort_nodone", 32'(done_cnt - d0), 32'd0);

        out_log.delete();
        start_frame(1'b1, p1);
        wait_done();
        check("retx_len13", 32'(out_log.size()), 32'd13);
        if (out_log.size() == 13)
            check("retx_fcs", {out_log[9], out_log[10], out_log[11], out_log[12]}, 32'hFC891918);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
